// File: rtl/hralm_prod_accumulator.sv
// Streaming signed accumulator for approximate-multiplier products: sums a vector of
// 32-bit products with saturation and hands the result out on a valid/ready port.
module hralm_prod_accumulator #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [31:0]      p_data,
    input  logic             p_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_sticky;

    logic             accept;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             ovf_upd;

    assign accept = p_valid & p_ready;

    // One guard bit is enough: disagreement between the top two bits means the
    // true sum left the ACC_W-bit signed range, and the guard bit gives its sign.
    always_comb begin
        sum_ext = {acc[ACC_W-1], acc} + {{(ACC_W+1-32){p_data[31]}}, p_data};
        acc_upd = sum_ext[ACC_W-1:0];
        ovf_upd = ovf_sticky;
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_upd = sum_ext[ACC_W] ? SAT_MIN : SAT_MAX;
            ovf_upd = 1'b1;
        end
        cnt_upd = (&cnt) ? cnt : cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // A last beat always (re)enters HOLD, even while draining a prior result.
    always_comb begin
        state_nxt = state;
        if (accept && p_last) begin
            state_nxt = HOLD;
        end else if (state == HOLD && out_ready) begin
            state_nxt = ACC;
        end
    end

    always_comb begin
        out_valid = (state == HOLD);
        p_ready   = (state == ACC) | out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            out_sum    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else if (accept) begin
            if (p_last) begin
                out_sum    <= acc_upd;
                out_count  <= cnt_upd;
                out_ovf    <= ovf_upd;
                acc        <= '0;
                cnt        <= '0;
                ovf_sticky <= 1'b0;
            end else begin
                acc        <= acc_upd;
                cnt        <= cnt_upd;
                ovf_sticky <= ovf_upd;
            end
        end
    end

endmodule

// File: tb/tb_hralm_prod_accumulator.sv
// Directed bench: a default-width instance and a narrow (ACC_W=33, CNT_W=2) instance
// share one stimulus stream so saturation of both sum and counter is reachable.
module tb_hralm_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p_valid;
    logic [31:0] p_data;
    logic        p_last;
    logic        out_ready;

    logic        p_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_sum_a;
    logic [15:0] out_count_a;

    logic        p_ready_b, out_valid_b, out_ovf_b;
    logic [32:0] out_sum_b;
    logic [1:0]  out_count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hralm_prod_accumulator #(.ACC_W(40), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_ready(p_ready_a),
        .p_data(p_data), .p_last(p_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
        .out_ovf(out_ovf_a)
    );

    hralm_prod_accumulator #(.ACC_W(33), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .p_valid(p_valid), .p_ready(p_ready_b),
        .p_data(p_data), .p_last(p_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
        .out_ovf(out_ovf_b)
    );

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        p_valid = v;
        p_data  = d;
        p_last  = l;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        step(); step();
        checks++;
        if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a} !== 58'h0) begin
            errors++;
            $display("FAIL reset_a: got v=%0b sum=%0h cnt=%0d ovf=%0b, want all 0",
                     out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        checks++;
        if (p_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_p_ready: got %0b want 1", p_ready_a);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_sum();
        out_ready = 1'b1;
        drive(1'b1, 32'd100, 1'b0); step();
        drive(1'b1, -32'sd50, 1'b0); step();
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_midvec_valid: got %0b want 0", out_valid_a);
        end
        drive(1'b1, 32'd7, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 40'd57 || out_count_a !== 16'd3 || out_ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got v=%0b sum=%0d cnt=%0d ovf=%0b, want v=1 sum=57 cnt=3 ovf=0",
                     out_valid_a, $signed(out_sum_a), out_count_a, out_ovf_a);
        end
        step();
        checks++;
        if (out_valid_a !== 1'b0 || out_sum_a !== 40'd57) begin
            errors++;
            $display("FAIL basic_drain: got v=%0b sum=%0d, want v=0 sum=57", out_valid_a, $signed(out_sum_a));
        end
    endtask

    task automatic test_single_neg_extreme();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 40'hFF_8000_0000 || out_count_a !== 16'd1 || out_ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL single_neg_a: got v=%0b sum=%0h cnt=%0d ovf=%0b, want v=1 sum=ff80000000 cnt=1 ovf=0",
                     out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        checks++;
        if (out_sum_b !== 33'h1_8000_0000 || out_ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL single_neg_b: got sum=%0h ovf=%0b, want sum=180000000 ovf=0", out_sum_b, out_ovf_b);
        end
        step();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        drive(1'b1, 32'h7FFF_FFFF, 1'b0); step();
        drive(1'b1, 32'h7FFF_FFFF, 1'b0); step();
        drive(1'b1, 32'h7FFF_FFFF, 1'b1); step();
        checks++;
        if (out_valid_b !== 1'b1 || out_sum_b !== 33'h0_FFFF_FFFF || out_ovf_b !== 1'b1 || out_count_b !== 2'd3) begin
            errors++;
            $display("FAIL sat_pos_b: got v=%0b sum=%0h cnt=%0d ovf=%0b, want v=1 sum=ffffffff cnt=3 ovf=1",
                     out_valid_b, out_sum_b, out_count_b, out_ovf_b);
        end
        checks++;
        if (out_sum_a !== 40'h01_7FFF_FFFD || out_ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL sat_pos_a: got sum=%0h ovf=%0b, want sum=017ffffffd ovf=0", out_sum_a, out_ovf_a);
        end
        // Back-to-back single-beat vector: sticky overflow must not leak into it.
        drive(1'b1, 32'd5, 1'b1); step();
        checks++;
        if (out_valid_b !== 1'b1 || out_sum_b !== 33'd5 || out_ovf_b !== 1'b0 || out_count_b !== 2'd1) begin
            errors++;
            $display("FAIL sat_sticky_clear: got v=%0b sum=%0d cnt=%0d ovf=%0b, want v=1 sum=5 cnt=1 ovf=0",
                     out_valid_b, out_sum_b, out_count_b, out_ovf_b);
        end
        drive(1'b1, 32'h8000_0000, 1'b0); step();
        drive(1'b1, 32'h8000_0000, 1'b0); step();
        drive(1'b1, 32'h8000_0000, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_sum_b !== 33'h1_0000_0000 || out_ovf_b !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg_b: got sum=%0h ovf=%0b, want sum=100000000 ovf=1", out_sum_b, out_ovf_b);
        end
        checks++;
        if (out_sum_a !== 40'hFE_8000_0000 || out_ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL sat_neg_a: got sum=%0h ovf=%0b, want sum=fe80000000 ovf=0", out_sum_a, out_ovf_a);
        end
        step();
    endtask

    task automatic test_count_saturation();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'd1, (i == 4)); step();
        end
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_count_b !== 2'd3 || out_ovf_b !== 1'b0 || out_sum_b !== 33'd5) begin
            errors++;
            $display("FAIL cnt_sat_b: got cnt=%0d ovf=%0b sum=%0d, want cnt=3 ovf=0 sum=5",
                     out_count_b, out_ovf_b, out_sum_b);
        end
        checks++;
        if (out_count_a !== 16'd5) begin
            errors++;
            $display("FAIL cnt_a: got %0d want 5", out_count_a);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 1'b1); step();
        drive(1'b1, 32'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (p_ready_a !== 1'b0 || out_valid_a !== 1'b1 || out_sum_a !== 40'd1 || out_count_a !== 16'd1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got p_ready=%0b v=%0b sum=%0d cnt=%0d, want p_ready=0 v=1 sum=1 cnt=1",
                         i, p_ready_a, out_valid_a, $signed(out_sum_a), out_count_a);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (p_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %0b want 1", p_ready_a);
        end
        step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 40'd9 || out_count_a !== 16'd1) begin
            errors++;
            $display("FAIL bp_next: got v=%0b sum=%0d cnt=%0d, want v=1 sum=9 cnt=1",
                     out_valid_a, $signed(out_sum_a), out_count_a);
        end
        step();
        checks++;
        if (out_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%0b want 0", out_valid_a);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 32'd2, 1'b1); step();
        out_ready = 1'b1;
        drive(1'b1, 32'd4, 1'b0); step();
        checks++;
        if (out_valid_a !== 1'b0 || out_sum_a !== 40'd2) begin
            errors++;
            $display("FAIL concur_drain: got v=%0b sum=%0d, want v=0 sum=2", out_valid_a, $signed(out_sum_a));
        end
        drive(1'b1, 32'd6, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 40'd10 || out_count_a !== 16'd2) begin
            errors++;
            $display("FAIL concur_result: got v=%0b sum=%0d cnt=%0d, want v=1 sum=10 cnt=2",
                     out_valid_a, $signed(out_sum_a), out_count_a);
        end
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'd1000, 1'b0); step();
        drive(1'b1, 32'd2000, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        step();
        checks++;
        if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a} !== 58'h0) begin
            errors++;
            $display("FAIL midreset_during: got v=%0b sum=%0h cnt=%0d ovf=%0b, want all 0",
                     out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid_a, out_sum_a, out_count_a, out_ovf_a} !== 58'h0) begin
            errors++;
            $display("FAIL midreset_after: got v=%0b sum=%0h cnt=%0d ovf=%0b, want all 0",
                     out_valid_a, out_sum_a, out_count_a, out_ovf_a);
        end
        drive(1'b1, 32'd3, 1'b1); step();
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (out_valid_a !== 1'b1 || out_sum_a !== 40'd3 || out_count_a !== 16'd1) begin
            errors++;
            $display("FAIL midreset_result: got v=%0b sum=%0d cnt=%0d, want v=1 sum=3 cnt=1",
                     out_valid_a, $signed(out_sum_a), out_count_a);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_single_neg_extreme();
        test_saturation();
        test_count_saturation();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hralm_prod_accumulator.md
Name: hralm_prod_accumulator

Overview:
- Streaming accumulator directly downstream of the 16x16 hybrid radix-4/log approximate multiplier.
- Consumes the multiplier's 32-bit signed product one beat per cycle and sums a vector of products into a wide signed accumulator.
- Emits the dot-product result, term count and overflow flag on a valid/ready output port.
- Used for error-tolerant dot products and MAC accuracy benchmarking of the approximate multiplier.

Parameters:
- ACC_W, 40, accumulator/result width in bits, signed; legal range 33..64.
- CNT_W, 16, term-counter width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- p_valid  input  1  product beat valid.
- p_ready  output  1  product beat accepted when p_valid & p_ready.
- p_data  input  32  signed product from the multiplier (two's complement).
- p_last  input  1  marks the final product of the current vector.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid & out_ready.
- out_sum  output  ACC_W  signed accumulated sum of the vector.
- out_count  output  CNT_W  number of products accumulated in the vector.
- out_ovf  output  1  set if any saturation occurred in the vector.

Behaviour:
- Reset (rst_n=0 at a clock edge): acc=0, cnt=0, ovf_sticky=0, out_valid=0, out_sum=0, out_count=0, out_ovf=0. Reset overrides all handshakes and aborts any partial vector or pending result.
- Two states:
  - ACC: out_valid=0.
  - HOLD: out_valid=1.
  - out_valid is a register, not combinational.
- p_ready = ~out_valid | out_ready. It is combinational from out_ready, and it is 1 in ACC.
- Beat accept (p_valid & p_ready):
  - Compute s = acc + sign_extend(p_data, ACC_W) at ACC_W+1 bits.
  - If s exceeds max signed ACC_W, clamp to 2^(ACC_W-1)-1 and set ovf. If s is below min, clamp to -2^(ACC_W-1) and set ovf.
  - cnt increments and saturates at 2^CNT_W-1. Counter saturation does not set ovf.
- Beat with p_last=0: acc, cnt and ovf_sticky take their updated values.
- Beat with p_last=1:
  - out_sum, out_count and out_ovf load the updated (post-beat) values.
  - acc, cnt and ovf_sticky clear to 0 on the same edge.
  - State goes to HOLD, so out_valid=1 from the next cycle. Latency from last-beat accept to out_valid is 1 cycle.
- HOLD:
  - out_sum, out_count and out_ovf hold stable while out_valid & ~out_ready.
  - p_ready=0 in that case, so no beat is accepted or lost, and p_data is not sampled.
- Output handshake (out_valid & out_ready):
  - Without a simultaneous last beat: return to ACC and out_valid=0 next cycle. The out_* registers retain their old values.
  - With a simultaneous accepted p_last beat: stay in HOLD and load the new result. This gives back-to-back results at one per cycle.
  - With a simultaneous non-last beat: the beat is accumulated into the freshly cleared acc.
- Back-to-back vectors need no idle cycle. A vector of one beat (p_last on the first beat) is legal: out_count=1.
- p_last with p_valid=0 is ignored.
- Accumulation is exact whenever no clamp occurs. The block adds no approximation of its own.

Test Plan:
- Basic sum: beats 100, -50, 7(last) on consecutive cycles, out_ready=1 -> one cycle after the third beat, out_valid=1, out_sum=57, out_count=3, out_ovf=0. Next cycle out_valid=0.
- Single-beat vector with negative extreme: p_data=32'h8000_0000, p_last=1 -> out_sum=-2147483648 sign-extended to ACC_W, out_count=1, out_ovf=0.
- Saturation with ACC_W=33: beats 32'h7FFF_FFFF x2 -> internal acc=4294967294, no ovf. Third beat 32'h7FFF_FFFF(last) -> out_sum=4294967295 (max), out_ovf=1. The following vector 5(last) -> out_sum=5, out_ovf=0 (sticky cleared).
- Backpressure: result pending, out_ready=0 for 5 cycles while p_valid=1 holds 9(last) -> p_ready=0 for all 5 cycles and out_* stable. When out_ready=1, 9 is accepted the same cycle and the next result is out_sum=9, out_count=1 with out_valid continuous.
- Concurrent drain and accumulate: out_valid=1, out_ready=1, non-last beat 4 accepted on the same edge, then 6(last) -> first result consumed, out_valid=0 one cycle, then out_sum=10, out_count=2.
- Mid-vector reset: accept 1000, 2000, pull rst_n=0 for one cycle, then 3(last) -> out_sum=3, out_count=1. All outputs read 0 during and immediately after reset.
